// File: rtl/ata_pio_sched.sv
// ata_pio_sched
// ----------------------------------------------------------------------------
// Round-robin scheduler and PIO timing sequencer that shares one ATA PIO port
// between two requesters (port 0: host path, port 1: command-queue engine).
// Each granted access walks through address setup (T1), strobe (T2 plus
// optional IORDY extension) and end-of-cycle (T4 write hold / Teoc).
//
// Ports
//   CLK_I, RST_I            clock, asynchronous active-high reset
//   en                      enable new grants (transfer in flight always ends)
//   iordy_en                honour IORDY at the end of T2
//   t1, t2, t4, teoc        phase lengths in clocks minus one
//   req0/1, we0/1           request (held until ack) and write flag per port
//   adr0/1                  [3] selects CS1n (1) or CS0n (0), [2:0] = DA
//   dat0/1                  write data per port
//   ack0/1                  one-cycle completion pulse per port
//   q                       last read data
//   busy                    high whenever the sequencer is not idle
//   DDi/DDo/DDoe            ATA data bus in / out / output enable
//   DA, CS0n, CS1n          ATA address and chip selects
//   DIORn, DIOWn            ATA read / write strobes
//   IORDY                   asynchronous device ready
//   dbg_state_o             current sequencer state (debug)
//
// Handshake: a requester raises reqN with weN/adrN/datN stable and holds it
// until ackN pulses; the operands are sampled once, in the grant cycle, so the
// requester may change them afterwards. ackN is high for exactly the last
// cycle of the transfer; dropping reqN early does not cancel the transfer.
// ----------------------------------------------------------------------------
module ata_pio_sched #(
  parameter int TWIDTH = 8
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              en,
  input  logic              iordy_en,
  input  logic [TWIDTH-1:0] t1,
  input  logic [TWIDTH-1:0] t2,
  input  logic [TWIDTH-1:0] t4,
  input  logic [TWIDTH-1:0] teoc,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [3:0]        adr0,
  input  logic [3:0]        adr1,
  input  logic [15:0]       dat0,
  input  logic [15:0]       dat1,
  output logic              ack0,
  output logic              ack1,
  output logic [15:0]       q,
  output logic              busy,
  input  logic [15:0]       DDi,
  output logic [15:0]       DDo,
  output logic              DDoe,
  output logic [2:0]        DA,
  output logic              CS0n,
  output logic              CS1n,
  output logic              DIORn,
  output logic              DIOWn,
  input  logic              IORDY,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;     // port served most recently
  logic              gnt_q, gnt_d;       // port owning the transfer in flight
  logic              we_q, we_d;
  logic [3:0]        adr_q, adr_d;
  logic [15:0]       dat_q, dat_d;
  logic [TWIDTH-1:0] t2_q, t2_d;
  logic [TWIDTH-1:0] t4_q, t4_d;
  logic [TWIDTH-1:0] teoc_q, teoc_d;
  logic [TWIDTH-1:0] cnt_q, cnt_d;       // phase counter
  logic [TWIDTH-1:0] hcnt_q, hcnt_d;     // write-hold counter inside END
  logic              hold_q, hold_d;     // write data still driven in END
  logic [15:0]       q_q, q_d;
  logic              iordy_s1_q;
  logic              iordy_s_q;

  logic              pick;               // port that would win arbitration now
  logic              cnt_zero;

  // With both requests pending the port not served last wins; otherwise the
  // single active requester wins.
  assign pick     = (req0 && req1) ? ~last_q : req1;
  assign cnt_zero = (cnt_q == '0);

  // IORDY is asynchronous to CLK_I.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      iordy_s1_q <= 1'b0;
      iordy_s_q  <= 1'b0;
    end else begin
      iordy_s1_q <= IORDY;
      iordy_s_q  <= iordy_s1_q;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      t2_q    <= '0;
      t4_q    <= '0;
      teoc_q  <= '0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      hold_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      t2_q    <= t2_d;
      t4_q    <= t4_d;
      teoc_q  <= teoc_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    t2_d    = t2_q;
    t4_d    = t4_q;
    teoc_d  = teoc_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    hold_d  = hold_q;
    q_d     = q_q;

    unique case (state_q)
      S_IDLE: begin
        if (en && (req0 || req1)) begin
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? we1  : we0;
          adr_d   = pick ? adr1 : adr0;
          dat_d   = pick ? dat1 : dat0;
          t2_d    = t2;
          t4_d    = t4;
          teoc_d  = teoc;
          cnt_d   = t1;
          hold_d  = 1'b0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = t2_q;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - TWIDTH'(1);
        end
      end

      S_STROBE: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - TWIDTH'(1);
        end else if (!(iordy_en && !iordy_s_q)) begin
          // Leaving STROBE is the strobe's rising edge: latch read data here.
          cnt_d   = (t4_q > teoc_q) ? t4_q : teoc_q;
          hcnt_d  = t4_q;
          hold_d  = 1'b1;
          state_d = S_END;
          if (!we_q) q_d = DDi;
        end
      end

      S_END: begin
        if (hcnt_q == '0) hold_d = 1'b0;
        else              hcnt_d = hcnt_q - TWIDTH'(1);
        if (cnt_zero) state_d = S_IDLE;
        else          cnt_d   = cnt_q - TWIDTH'(1);
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Pin decode works only from registered state, so every pin follows reset
  // immediately and CS/DA stay put across the whole transfer.
  always_comb begin
    busy  = (state_q != S_IDLE);
    CS0n  = !(busy && !adr_q[3]);
    CS1n  = !(busy &&  adr_q[3]);
    DA    = adr_q[2:0];
    DIORn = !((state_q == S_STROBE) && !we_q);
    DIOWn = !((state_q == S_STROBE) &&  we_q);
    DDo   = dat_q;
    DDoe  = we_q && ((state_q == S_SETUP) || (state_q == S_STROBE) ||
                     ((state_q == S_END) && hold_q));
    ack0  = (state_q == S_END) && cnt_zero && !gnt_q;
    ack1  = (state_q == S_END) && cnt_zero &&  gnt_q;
    q     = q_q;
    dbg_state_o = state_q;
  end

endmodule
